// File: rtl/cache_plru_tree_if.sv
// -----------------------------------------------------------------------------
// cache_plru_tree_if
// Request/response bundle between a tag pipeline (master) and the tree
// pseudo-LRU tracker (slave).
//
// Handshake: there is no backpressure. A request is a one-cycle pulse of
// access_en or fill_en, and the tracker takes it when init_done is high.
// update_en is a one-cycle pulse in the cycle after an access_en. fill_way_idx
// is valid in the cycle after fill_en and is 0 in every other cycle.
//
// Signals:
//   init_done      tracker -> tag  all sets initialised, requests honoured
//   access_en/set  tag -> tracker  cycle-1 lookup of a set
//   update_en/way  tag -> tracker  cycle-2 hit way for the looked-up set
//   fill_en/set    tag -> tracker  cycle-1 victim request
//   fill_way_idx   tracker -> tag  cycle-2 victim way
// -----------------------------------------------------------------------------
interface cache_plru_tree_if #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 16
);
  localparam int NUM_WAYS_LOG = $clog2(NUM_WAYS);
  localparam int NUM_SETS_LOG = $clog2(NUM_SETS);

  logic                    init_done;
  logic                    access_en;
  logic [NUM_SETS_LOG-1:0] access_set;
  logic                    update_en;
  logic [NUM_WAYS_LOG-1:0] update_way_idx;
  logic                    fill_en;
  logic [NUM_SETS_LOG-1:0] fill_set;
  logic [NUM_WAYS_LOG-1:0] fill_way_idx;

  modport master (
    output access_en, access_set, update_en, update_way_idx, fill_en, fill_set,
    input  init_done, fill_way_idx
  );

  modport slave (
    input  access_en, access_set, update_en, update_way_idx, fill_en, fill_set,
    output init_done, fill_way_idx
  );
endinterface

// File: rtl/cache_plru_tree.sv
// -----------------------------------------------------------------------------
// cache_plru_tree
// Tree pseudo-LRU replacement tracker. Each set holds NUM_WAYS-1 node bits in
// a 1-read/1-write synchronous memory (read data returns the old contents on
// a same-address read/write). After reset, a sweep writes zero into every
// set; then the tracker reads flags in cycle 1 and writes the touched flags
// in cycle 2.
//
// Optional feature macro: CACHE_PLRU_BYPASS_EN. When it is defined, a write
// that hits the set being read in the same cycle is forwarded, so
// back-to-back operations on one set see each other's update.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        cache_plru_tree_if slave modport (requests, victim, init_done)
//   dbg_state  FSM state: 0 = INIT (sweeping), 1 = READY
// -----------------------------------------------------------------------------
module cache_plru_tree #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_plru_tree_if.slave  bus,
  output logic              dbg_state
);
  localparam int NUM_WAYS_LOG = $clog2(NUM_WAYS);
  localparam int NUM_SETS_LOG = $clog2(NUM_SETS);
  localparam int NODES        = NUM_WAYS - 1;

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t                  state, state_next;
  logic [NUM_SETS_LOG-1:0] sweep_cnt;
  logic                    sweep_we;
  logic                    ready;

  logic                    read_en;
  logic [NUM_SETS_LOG-1:0] read_set;
  logic [NUM_SETS_LOG-1:0] write_set;
  logic                    was_fill;
  logic                    write_en;
  logic [NODES-1:0]        rd_data;
  logic [NODES-1:0]        flags_cur;
  logic [NODES-1:0]        new_flags;
  logic [NUM_WAYS_LOG-1:0] victim;
  logic [NUM_WAYS_LOG-1:0] touch_way;

  logic [NODES-1:0]        mem [NUM_SETS];
  logic                    mem_we;
  logic [NUM_SETS_LOG-1:0] mem_waddr;
  logic [NODES-1:0]        mem_wdata;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && sweep_cnt == NUM_SETS_LOG'(NUM_SETS - 1))
      state_next = ST_READY;
  end

  always_comb begin
    ready    = (state == ST_READY);
    sweep_we = (state == ST_INIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sweep_cnt <= '0;
    else if (sweep_we) sweep_cnt <= sweep_cnt + NUM_SETS_LOG'(1);
  end

  assign dbg_state     = state;
  assign bus.init_done = ready;

  // ------------------------------------------------------- cycle 1: read
  // Fill wins the single read port over a same-cycle access.
  assign read_en  = (bus.access_en | bus.fill_en) & ready;
  assign read_set = bus.fill_en ? bus.fill_set : bus.access_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_set <= '0;
      was_fill  <= 1'b0;
      rd_data   <= '0;
    end else begin
      was_fill <= read_en & bus.fill_en;
      if (read_en) begin
        write_set <= read_set;
        rd_data   <= mem[read_set];
      end
    end
  end

  // ------------------------------------------------ same-set forwarding
`ifdef CACHE_PLRU_BYPASS_EN
  logic             byp_valid;
  logic [NODES-1:0] byp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_valid <= 1'b0;
      byp_data  <= '0;
    end else begin
      byp_valid <= write_en & read_en & (write_set == read_set);
      byp_data  <= new_flags;
    end
  end

  assign flags_cur = byp_valid ? byp_data : rd_data;
`else
  assign flags_cur = rd_data;
`endif

  // ------------------------------------------------------ cycle 2: walk
  // Follow the node bits from the root; each level contributes one bit of
  // the way index, MSB first.
  always_comb begin
    logic [NUM_WAYS_LOG-1:0] node;
    logic                    b;
    node   = '0;
    b      = 1'b0;
    victim = '0;
    for (int lvl = 0; lvl < NUM_WAYS_LOG; lvl++) begin
      b = flags_cur[node];
      victim[NUM_WAYS_LOG-1-lvl] = b;
      node = (node << 1) + NUM_WAYS_LOG'(1) + NUM_WAYS_LOG'(b);
    end
  end

  // A hit notification in the same cycle as a fill result is dropped.
  assign write_en  = ready & (was_fill | bus.update_en);
  assign touch_way = was_fill ? victim : bus.update_way_idx;

  // Every node on the touched way's path points to the other subtree.
  always_comb begin
    logic [NUM_WAYS_LOG-1:0] node;
    logic                    b;
    node      = '0;
    b         = 1'b0;
    new_flags = flags_cur;
    for (int lvl = 0; lvl < NUM_WAYS_LOG; lvl++) begin
      b = touch_way[NUM_WAYS_LOG-1-lvl];
      new_flags[node] = ~b;
      node = (node << 1) + NUM_WAYS_LOG'(1) + NUM_WAYS_LOG'(b);
    end
  end

  assign bus.fill_way_idx = was_fill ? victim : '0;

  // ----------------------------------------------------- flag storage
  // Sweep and normal writes are exclusive: write_en requires READY.
  assign mem_we    = sweep_we | write_en;
  assign mem_waddr = sweep_we ? sweep_cnt : write_set;
  assign mem_wdata = sweep_we ? '0 : new_flags;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
endmodule

// File: tb/tb_cache_plru_tree.sv
module tb_cache_plru_tree;
  logic clk;
  logic rst_n;
  logic dbg4, dbg8;
  int   checks   = 0;
  int   failures = 0;
  logic prev_acc4;

  cache_plru_tree_if #(.NUM_WAYS(4), .NUM_SETS(16)) if4 ();
  cache_plru_tree_if #(.NUM_WAYS(8), .NUM_SETS(16)) if8 ();

  cache_plru_tree #(.NUM_WAYS(4), .NUM_SETS(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4), .dbg_state(dbg4)
  );
  cache_plru_tree #(.NUM_WAYS(8), .NUM_SETS(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8), .dbg_state(dbg8)
  );

  // ---------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An update must follow an access in the previous cycle.
  always @(posedge clk) begin
    if (rst_n && if4.update_en && !prev_acc4)
      $error("update_en without a preceding access_en");
    prev_acc4 <= if4.access_en;
  end

  // ---------------------------------------------------- driver tasks
  task automatic idle_inputs();
    if4.access_en = 0; if4.access_set = 0; if4.update_en = 0;
    if4.update_way_idx = 0; if4.fill_en = 0; if4.fill_set = 0;
    if8.access_en = 0; if8.access_set = 0; if8.update_en = 0;
    if8.update_way_idx = 0; if8.fill_en = 0; if8.fill_set = 0;
  endtask

  // Count rising edges until init_done rises (bounded); also note whether
  // fill_way_idx ever left 0 during the sweep.
  task automatic wait_init(output int cyc, output bit way_zero);
    cyc = 0;
    way_zero = 1;
    while (!if4.init_done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (if4.fill_way_idx !== 2'd0 || if8.fill_way_idx !== 3'd0) way_zero = 0;
    end
  endtask

  task automatic fill4(input logic [3:0] set, output logic [1:0] way);
    @(negedge clk);
    if4.fill_en = 1; if4.fill_set = set;
    @(negedge clk);
    if4.fill_en = 0;
    way = if4.fill_way_idx;
  endtask

  task automatic fill8(input logic [3:0] set, output logic [2:0] way);
    @(negedge clk);
    if8.fill_en = 1; if8.fill_set = set;
    @(negedge clk);
    if8.fill_en = 0;
    way = if8.fill_way_idx;
  endtask

  // ---------------------------------------------------- scenarios
  task automatic test_reset();
    int cyc;
    bit way_zero;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (if4.init_done !== 1'b0 || if8.init_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_init_done got=%b/%b exp=0/0", if4.init_done, if8.init_done);
    end
    checks++;
    if (if4.fill_way_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_fill_way got=%0d exp=0", if4.fill_way_idx);
    end
    checks++;
    if (dbg4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=0", dbg4);
    end
    @(negedge clk);
    rst_n = 1;
    wait_init(cyc, way_zero);
    checks++;
    if (cyc !== 16) begin
      failures++;
      $display("FAIL init_length got=%0d exp=16", cyc);
    end
    checks++;
    if (!way_zero) begin
      failures++;
      $display("FAIL init_fill_way got=nonzero exp=0");
    end
    checks++;
    if (if8.init_done !== 1'b1 || dbg4 !== 1'b1 || dbg8 !== 1'b1) begin
      failures++;
      $display("FAIL init_ready got=%b/%b/%b exp=1/1/1", if8.init_done, dbg4, dbg8);
    end
  endtask

  task automatic test_fill_sequence();
    logic [1:0] exp_way [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
    logic [1:0] got;
    for (int i = 0; i < 5; i++) begin
      fill4(4'd5, got);
      @(negedge clk);  // idle cycle between fills
      checks++;
      if (got !== exp_way[i]) begin
        failures++;
        $display("FAIL fill_seq[%0d] got=%0d exp=%0d", i, got, exp_way[i]);
      end
    end
  endtask

  task automatic test_access_update();
    logic [1:0] got;
    fill4(4'd3, got);
    checks++;
    if (got !== 2'd0) begin
      failures++;
      $display("FAIL acc_upd_first got=%0d exp=0", got);
    end
    @(negedge clk);
    if4.access_en = 1; if4.access_set = 4'd3;
    @(negedge clk);
    if4.access_en = 0; if4.update_en = 1; if4.update_way_idx = 2'd2;
    checks++;
    if (if4.fill_way_idx !== 2'd0) begin
      failures++;
      $display("FAIL acc_no_victim got=%0d exp=0", if4.fill_way_idx);
    end
    @(negedge clk);
    if4.update_en = 0;
    fill4(4'd3, got);
    checks++;
    if (got !== 2'd1) begin
      failures++;
      $display("FAIL acc_upd_protect got=%0d exp=1", got);
    end
  endtask

  task automatic test_fill_access_concurrent();
    logic [1:0] got;
    @(negedge clk);
    if4.fill_en = 1; if4.fill_set = 4'd7;
    if4.access_en = 1; if4.access_set = 4'd2;
    @(negedge clk);
    if4.fill_en = 0; if4.access_en = 0;
    if4.update_en = 1; if4.update_way_idx = 2'd3;
    checks++;
    if (if4.fill_way_idx !== 2'd0) begin
      failures++;
      $display("FAIL conc_victim got=%0d exp=0", if4.fill_way_idx);
    end
    @(negedge clk);
    if4.update_en = 0;
    fill4(4'd2, got);
    checks++;
    if (got !== 2'd0) begin
      failures++;
      $display("FAIL conc_set2_untouched got=%0d exp=0", got);
    end
    fill4(4'd7, got);
    checks++;
    if (got !== 2'd2) begin
      failures++;
      $display("FAIL conc_set7_fill_only got=%0d exp=2", got);
    end
  endtask

  task automatic test_back_to_back();
`ifdef CACHE_PLRU_BYPASS_EN
    logic [2:0] exp_way [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
`else
    // Without forwarding each read misses the write of the previous cycle.
    logic [2:0] exp_way [8] = '{3'd0, 3'd0, 3'd4, 3'd4, 3'd2, 3'd2, 3'd6, 3'd6};
`endif
    logic [2:0] got;
    @(negedge clk);
    if8.fill_en = 1; if8.fill_set = 4'd9;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got = if8.fill_way_idx;
      if (i == 7) if8.fill_en = 0;
      checks++;
      if (got !== exp_way[i]) begin
        failures++;
        $display("FAIL b2b[%0d] got=%0d exp=%0d", i, got, exp_way[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int cyc;
    bit way_zero;
    logic [1:0] got4;
    logic [2:0] got8;
    @(negedge clk);
    if4.fill_en = 1; if4.fill_set = 4'd5;
    @(negedge clk);
    if4.fill_set = 4'd6;
    #2 rst_n = 0;
    #1;
    checks++;
    if (if4.init_done !== 1'b0 || dbg4 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_init got=%b state=%b exp=0", if4.init_done, dbg4);
    end
    checks++;
    if (if4.fill_way_idx !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset_way got=%0d exp=0", if4.fill_way_idx);
    end
    if4.fill_en = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    wait_init(cyc, way_zero);
    checks++;
    if (cyc !== 16) begin
      failures++;
      $display("FAIL mid_reinit_length got=%0d exp=16", cyc);
    end
    fill4(4'd5, got4);
    checks++;
    if (got4 !== 2'd0) begin
      failures++;
      $display("FAIL mid_set5 got=%0d exp=0", got4);
    end
    fill4(4'd3, got4);
    checks++;
    if (got4 !== 2'd0) begin
      failures++;
      $display("FAIL mid_set3 got=%0d exp=0", got4);
    end
    fill8(4'd9, got8);
    checks++;
    if (got8 !== 3'd0) begin
      failures++;
      $display("FAIL mid_set9_w8 got=%0d exp=0", got8);
    end
  endtask

  // ---------------------------------------------------- sequence + report
  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_fill_sequence();
    test_access_update();
    test_fill_access_concurrent();
    test_back_to_back();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_plru_tree.md
# cache_plru_tree

Parametrised tree pseudo-LRU replacement tracker for set-associative caches, superseding the fixed 4-way tracker. Stores NUM_WAYS-1 PLRU node bits per set in an `sram_1r1w`, self-initialises every set after reset with a sweep state machine, and resolves back-to-back same-set read/write hazards. It sits beside each L1/L2 tag array: the tag stage issues `access`/`fill` in cycle 1 and returns the hit way or consumes the victim way in cycle 2.

## Interface
- NUM_WAYS, 4: associativity; power of two, 2..32.
- NUM_SETS, 16: number of sets; power of two, >= 2.
- NUM_WAYS_LOG, $clog2(NUM_WAYS): way index width (derived).
- NUM_SETS_LOG, $clog2(NUM_SETS): set index width (derived).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once all sets are initialised; requests are ignored while low.
- access_en  in  1  cycle-1 lookup request.
- access_set  in  NUM_SETS_LOG  lookup set.
- update_en  in  1  cycle-2 hit notification for the set accessed in the previous cycle.
- update_way_idx  in  NUM_WAYS_LOG  way that hit.
- fill_en  in  1  cycle-1 victim request.
- fill_set  in  NUM_SETS_LOG  set to fill.
- fill_way_idx  out  NUM_WAYS_LOG  victim way; valid in the cycle after `fill_en`, 0 otherwise.

## Operation
- Tree layout: node 0 is the root; node i has children 2i+1 (left) and 2i+2 (right); leaves map to ways 0..NUM_WAYS-1 in left-to-right order.
- Node bit semantics: 0 means the victim lies in the left subtree; 1 means it lies in the right subtree.
- Victim selection: walk from the root following the node bits, log2(NUM_WAYS) levels. The leaf reached is `fill_way_idx`.
- Touch of way w: every node on w's path is set to point away from w. All other bits keep the value read.
- Cycle 1:
  - read_en = (access_en | fill_en) & init_done.
  - read set = fill_set if fill_en, else access_set. Fill wins over access.
  - The read set is latched as write_set. The fill flag is latched as was_fill (reset 0).
- Cycle 2:
  - write_en = was_fill | update_en.
  - The touched way is fill_way_idx if was_fill, else update_way_idx. A concurrent update_en is dropped when was_fill is set.
  - The new flags are written to write_set.
- update_en without a preceding access_en in the prior cycle is illegal. Behaviour is undefined, and the bench asserts on it.
- State machine:
  - INIT: after reset, a set counter runs 0..NUM_SETS-1. Each cycle it writes all-zero flags to the counter's set. init_done = 0. All requests are ignored and nothing is latched.
  - READY: entered the cycle after the counter writes NUM_SETS-1. init_done = 1. The block stays in READY until reset.
- Asynchronous reset at any time returns the block to INIT with the counter at 0. was_fill and the bypass registers clear. The sweep restarts fully.
- Reset values: init_done = 0, fill_way_idx = 0, all internal flops = 0.

## Timing
- INIT lasts exactly NUM_SETS cycles after rst_n deasserts. The first request can be accepted on cycle NUM_SETS.
- Victim latency is 1 cycle: `fill_way_idx` is combinational from the SRAM read data (or bypass data) in the cycle after `fill_en`.
- The SRAM returns old data when read and write hit the same address in the same cycle; the bypass below hides this.
- Requests are fully pipelined: a new `access_en`/`fill_en` is accepted every cycle with no stall. The block has no backpressure.

## Configuration
- CACHE_PLRU_BYPASS_EN defined:
  - If write_en is set and write_set equals the read set in the same cycle, the written flags are registered.
  - In the next cycle those registered flags replace the SRAM read data.
  - Result: back-to-back operations on the same set see each other's update.
- Undefined: no forwarding. A same-set read in the write cycle sees stale flags. Consecutive fills to one set may return the same way. Saves NUM_WAYS-1+1 flops and one comparator.

## Test plan
- Reset, hold rst_n low for 3 cycles, release → init_done low for exactly NUM_SETS (16) cycles, then high; fill_way_idx = 0 throughout.
- NUM_WAYS=4, four fills to set 5 spaced 2 cycles apart → victims 0, 2, 1, 3; a fifth fill → 0.
- NUM_WAYS=4, set 3: fill, then access+update way 2, then fill → victims 0 then 1 (way 2 protected).
- fill_en and access_en asserted together (fill_set=7, access_set=2), with update_en in the next cycle → only set 7 is updated; set 2 is unchanged (its next fill returns 0).
- With CACHE_PLRU_BYPASS_EN, NUM_WAYS=8, fills to set 9 on 8 consecutive cycles → victims 0,4,2,6,1,5,3,7, all distinct. Without the macro, the second victim repeats 0.
- Assert rst_n during mid-stream fills after init → init_done drops immediately and the sweep reruns; the next fill to any set → 0.
